// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dds_sweep_ctrl                                             |
// | Description : Linear frequency-sweep sequencer feeding the dds freq_in.  |
// |               Optional up/down sweep when SWEEP_BIDIR_EN is defined.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dds_sweep_ctrl #(
  parameter int N       = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N:0]         f_start,
  input  logic [N:0]         f_stop,
  input  logic [N:0]         f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N:0]         freq_out,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef SWEEP_BIDIR_EN
    ST_DOWN = 2'd2,
`endif
    ST_HOLD = 2'd1
  } state_t;

  state_t             r_state;
  logic [N:0]         r_f_start;
  logic [N:0]         r_f_stop;
  logic [N:0]         r_f_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;

  // Distances are taken one bit wider so the clamp decision can never wrap.
  logic [N+1:0] w_up_gap;
  logic         w_up_clamp;
  logic [N:0]   w_up_next;
  logic         w_single;
  logic         w_at_stop;

  assign w_up_gap   = {1'b0, r_f_stop} - {1'b0, freq_out};
  assign w_up_clamp = (w_up_gap <= {1'b0, r_f_step});
  assign w_up_next  = freq_out + r_f_step;
  assign w_single   = (r_f_step == '0) || (r_f_start >= r_f_stop);
  assign w_at_stop  = (freq_out == r_f_stop);

`ifdef SWEEP_BIDIR_EN
  logic [N+1:0] w_dn_gap;
  logic         w_dn_clamp;
  logic [N:0]   w_dn_next;
  logic         w_at_start;

  assign w_dn_gap   = {1'b0, freq_out} - {1'b0, r_f_start};
  assign w_dn_clamp = (w_dn_gap <= {1'b0, r_f_step});
  assign w_dn_next  = freq_out - r_f_step;
  assign w_at_start = (freq_out == r_f_start);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_f_start   <= '0;
      r_f_stop    <= '0;
      r_f_step    <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      freq_out    <= '0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_f_start   <= f_start;
              r_f_stop    <= f_stop;
              r_f_step    <= f_step;
              r_dwell     <= dwell;
              r_cnt       <= dwell;
              freq_out    <= f_start;
              step_strobe <= 1'b1;
              busy        <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DWELL_W'(1);
            end else if (w_at_stop || w_single) begin
`ifdef SWEEP_BIDIR_EN
              if (!w_single) begin
                // Turn-around: f_stop is not repeated, first down point follows.
                freq_out    <= w_dn_clamp ? r_f_start : w_dn_next;
                step_strobe <= 1'b1;
                r_cnt       <= r_dwell;
                r_state     <= ST_DOWN;
              end else
`endif
              begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= ST_IDLE;
              end
            end else begin
              freq_out    <= w_up_clamp ? r_f_stop : w_up_next;
              step_strobe <= 1'b1;
              r_cnt       <= r_dwell;
            end
          end
`ifdef SWEEP_BIDIR_EN
          ST_DOWN: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - DWELL_W'(1);
            end else if (w_at_start) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              freq_out    <= w_dn_clamp ? r_f_start : w_dn_next;
              step_strobe <= 1'b1;
              r_cnt       <= r_dwell;
            end
          end
`endif
          default: begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dds_sweep_ctrl                                          |
// | Description : Self-checking bench for dds_sweep_ctrl (reference model).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dds_sweep_ctrl;
  localparam int N       = 8;
  localparam int DWELL_W = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [N:0]         f_start;
  logic [N:0]         f_stop;
  logic [N:0]         f_step;
  logic [DWELL_W-1:0] dwell;
  logic [N:0]         freq_out;
  logic               busy;
  logic               step_strobe;
  logic               done;

  int errors = 0;
  int checks = 0;
  int last_f = 0;
  int exp_f[$];
  bit exp_s[$];

  always #5 clock = ~clock;

  dds_sweep_ctrl #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .freq_out    (freq_out),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int f, input bit b, input bit s, input bit d);
    check({tag, ".freq"},   32'(freq_out),    f);
    check({tag, ".busy"},   32'(busy),        32'(b));
    check({tag, ".strobe"}, 32'(step_strobe), 32'(s));
    check({tag, ".done"},   32'(done),        32'(d));
  endtask

  // Sweep as a list of visited tuning words, each expanded to dwell+1 cycles.
  function automatic void build(input int fs, input int fe, input int fst, input int dw);
    int pts[$];
    int v;
    exp_f.delete();
    exp_s.delete();
    pts.push_back(fs);
    if (fst != 0 && fs < fe) begin
      v = fs;
      while (v != fe) begin
        v = (fe - v <= fst) ? fe : v + fst;
        pts.push_back(v);
      end
`ifdef SWEEP_BIDIR_EN
      while (v != fs) begin
        v = (v - fs <= fst) ? fs : v - fst;
        pts.push_back(v);
      end
`endif
    end
    foreach (pts[i]) begin
      for (int k = 0; k <= dw; k++) begin
        exp_f.push_back(pts[i]);
        exp_s.push_back(k == 0);
      end
    end
  endfunction

  task automatic do_start(input int fs, input int fe, input int fst, input int dw);
    f_start = 9'(fs);
    f_stop  = 9'(fe);
    f_step  = 9'(fst);
    dwell   = 16'(dw);
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    f_start = 9'($urandom);
    f_stop  = 9'($urandom);
    f_step  = 9'($urandom);
    dwell   = 16'($urandom_range(0, 7));
  endtask

  // abort_at: -1 none, -2 random cycle, otherwise that busy-cycle index.
  task automatic follow(input int fs, input int fe, input int fst, input int dw,
                        input int abort_at, input bit chain);
    int ab;
    build(fs, fe, fst, dw);
    ab = (abort_at == -2) ? int'($urandom_range(0, exp_f.size() - 1)) : abort_at;
    for (int j = 0; j < exp_f.size(); j++) begin
      check_out("sweep", exp_f[j], 1'b1, exp_s[j], 1'b0);
      if (j == ab) begin
        abort = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clock);
        abort  = 1'b0;
        start  = 1'b0;
        last_f = exp_f[j];
        check_out("abort", last_f, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check_out("abort_idle", last_f, 1'b0, 1'b0, 1'b0);
        return;
      end
      start = ($urandom_range(0, 7) == 0);
      @(negedge clock);
      start = 1'b0;
    end
    last_f = exp_f[exp_f.size() - 1];
    check_out("done", last_f, 1'b0, 1'b0, 1'b1);
    if (!chain) begin
      @(negedge clock);
      check_out("idle", last_f, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int fs, fe, fst, dw, ab;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    f_start = '0;
    f_stop  = '0;
    f_step  = '0;
    dwell   = '0;
    repeat (2) @(negedge clock);
    check_out("reset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_out("post_reset", 0, 1'b0, 1'b0, 1'b0);

    do_start(10, 40, 10, 2);    follow(10, 40, 10, 2, -1, 1'b0);
    do_start(10, 35, 10, 0);    follow(10, 35, 10, 0, -1, 1'b0);
    do_start(500, 511, 300, 0); follow(500, 511, 300, 0, -1, 1'b0);
    do_start(50, 20, 10, 3);    follow(50, 20, 10, 3, -1, 1'b0);
    do_start(50, 200, 0, 3);    follow(50, 200, 0, 3, -1, 1'b0);
    do_start(10, 40, 10, 2);    follow(10, 40, 10, 2, 3, 1'b0);

    // Simultaneous start and abort from idle must not launch a sweep.
    f_start = 9'd100;
    f_stop  = 9'd200;
    f_step  = 9'd10;
    dwell   = 16'd1;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check_out("start_abort", last_f, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_out("start_abort2", last_f, 1'b0, 1'b0, 1'b0);

    // Start presented in the cycle done is high is accepted.
    do_start(10, 40, 10, 0);    follow(10, 40, 10, 0, -1, 1'b1);
    do_start(100, 130, 15, 1);  follow(100, 130, 15, 1, -1, 1'b0);

    // Reset in mid-sweep clears everything without a done pulse.
    do_start(10, 40, 10, 2);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_out("reset_mid", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset  = 1'b0;
    last_f = 0;
    @(negedge clock);
    check_out("reset_idle", 0, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        fs  = int'($urandom_range(400, 511));
        fe  = 511;
        fst = int'($urandom_range(50, 400));
      end else begin
        fs  = int'($urandom_range(0, 511));
        fe  = int'($urandom_range(0, 511));
        fst = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 160));
      end
      dw = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? -2 : -1;
      do_start(fs, fe, fst, dw);
      follow(fs, fe, fst, dw, ab, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
